// File: rtl/srfpu_pkg.sv
// Shared types for the two-requester SRFPU PCPI arbiter: FSM encoding and PCPI request fields.
package srfpu_pkg;

    localparam int PCPI_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ISSUE   = 2'd1;
    localparam state_t ST_RELEASE = 2'd2;

    typedef struct packed {
        logic [PCPI_W-1:0] insn;
        logic [PCPI_W-1:0] rs1;
        logic [PCPI_W-1:0] rs2;
    } pcpi_req_t;

endpackage

// File: rtl/srfpu_rr_pick.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to rr_ptr.
module srfpu_rr_pick (
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    output logic       grant_idx,
    output logic       grant_valid
);

    assign grant_valid = |valid;
    assign grant_idx   = (&valid) ? rr_ptr : valid[1];

endmodule

// File: rtl/srfpu_pcpi_arb.sv
// Arbitrates two PCPI requesters onto one shared SRFPU, with a timeout that lets the
// owning core fall through to its illegal-instruction trap when the SRFPU never answers.
module srfpu_pcpi_arb
    import srfpu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              m0_pcpi_valid,
    input  logic [PCPI_W-1:0] m0_pcpi_insn,
    input  logic [PCPI_W-1:0] m0_pcpi_rs1,
    input  logic [PCPI_W-1:0] m0_pcpi_rs2,
    output logic              m0_pcpi_wr,
    output logic [PCPI_W-1:0] m0_pcpi_rd,
    output logic              m0_pcpi_wait,
    output logic              m0_pcpi_ready,

    input  logic              m1_pcpi_valid,
    input  logic [PCPI_W-1:0] m1_pcpi_insn,
    input  logic [PCPI_W-1:0] m1_pcpi_rs1,
    input  logic [PCPI_W-1:0] m1_pcpi_rs2,
    output logic              m1_pcpi_wr,
    output logic [PCPI_W-1:0] m1_pcpi_rd,
    output logic              m1_pcpi_wait,
    output logic              m1_pcpi_ready,

    output logic              s_pcpi_valid,
    output logic [PCPI_W-1:0] s_pcpi_insn,
    output logic [PCPI_W-1:0] s_pcpi_rs1,
    output logic [PCPI_W-1:0] s_pcpi_rs2,
    input  logic              s_pcpi_wr,
    input  logic [PCPI_W-1:0] s_pcpi_rd,
    input  logic              s_pcpi_wait,
    input  logic              s_pcpi_ready,

    output logic              grant_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    state_t            state;
    logic              owner;
    logic              rr_ptr;
    logic [CNT_W-1:0]  cnt;
    pcpi_req_t         hold;
    logic              s_valid_reg;
    logic              ready_reg;
    logic              wr_reg;
    logic [PCPI_W-1:0] rd_reg;
    logic              timeout_reg;

    logic pick_idx;
    logic pick_valid;
    logic owner_valid;
    logic busy;
    logic in_issue;
    logic cnt_live;

    srfpu_rr_pick u_pick (
        .valid       ({m1_pcpi_valid, m0_pcpi_valid}),
        .rr_ptr      (rr_ptr),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    assign owner_valid = owner ? m1_pcpi_valid : m0_pcpi_valid;
    assign busy        = (state != ST_IDLE);
    assign in_issue    = (state == ST_ISSUE);
    assign cnt_live    = (cnt < CNT_LIMIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            rr_ptr      <= 1'b0;
            cnt         <= '0;
            hold        <= '0;
            s_valid_reg <= 1'b0;
            ready_reg   <= 1'b0;
            wr_reg      <= 1'b0;
            rd_reg      <= '0;
            timeout_reg <= 1'b0;
        end else begin
            ready_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner       <= pick_idx;
                        hold        <= pick_idx ? '{m1_pcpi_insn, m1_pcpi_rs1, m1_pcpi_rs2}
                                                : '{m0_pcpi_insn, m0_pcpi_rs1, m0_pcpi_rs2};
                        s_valid_reg <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Abort outranks a coincident ready so a withdrawn core never sees a result.
                    if (!owner_valid) begin
                        s_valid_reg <= 1'b0;
                        rr_ptr      <= ~owner;
                        state       <= ST_RELEASE;
                    end else if (s_pcpi_ready) begin
                        ready_reg   <= 1'b1;
                        wr_reg      <= s_pcpi_wr;
                        rd_reg      <= s_pcpi_rd;
                        s_valid_reg <= 1'b0;
                        rr_ptr      <= ~owner;
                        state       <= ST_RELEASE;
                    end else if (s_pcpi_wait) begin
                        cnt <= '0;
                    end else if (!cnt_live) begin
                        timeout_reg <= 1'b1;
                        s_valid_reg <= 1'b0;
                        rr_ptr      <= ~owner;
                        state       <= ST_RELEASE;
                    end else begin
                        cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
                    end
                end
                ST_RELEASE: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Stall only while the arbiter is busy, so reset leaves every output low.
    assign m0_pcpi_wait = busy && m0_pcpi_valid &&
                          (owner || (in_issue && (s_pcpi_wait || cnt_live)));
    assign m1_pcpi_wait = busy && m1_pcpi_valid &&
                          (!owner || (in_issue && (s_pcpi_wait || cnt_live)));

    assign m0_pcpi_ready = ready_reg && !owner;
    assign m1_pcpi_ready = ready_reg && owner;
    assign m0_pcpi_wr    = m0_pcpi_ready && wr_reg;
    assign m1_pcpi_wr    = m1_pcpi_ready && wr_reg;
    assign m0_pcpi_rd    = m0_pcpi_ready ? rd_reg : '0;
    assign m1_pcpi_rd    = m1_pcpi_ready ? rd_reg : '0;

    assign s_pcpi_valid = s_valid_reg;
    assign s_pcpi_insn  = hold.insn;
    assign s_pcpi_rs1   = hold.rs1;
    assign s_pcpi_rs2   = hold.rs2;

    assign grant_o   = busy && owner;
    assign busy_o    = busy;
    assign timeout_o = timeout_reg;

endmodule

// File: doc/srfpu_pcpi_arb.md
SRFPU_PCPI_ARB -- requirements
Module: srfpu_pcpi_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning idle cycles allowed between downstream issue and downstream wait or ready.
REQ-002 SHALL have parameter CNT_W, default 5, meaning timeout counter width; CNT_W SHALL be at least clog2(TIMEOUT+1).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 mK_pcpi_valid  in  1  requester K (K=0,1) instruction valid.
REQ-006 mK_pcpi_insn / mK_pcpi_rs1 / mK_pcpi_rs2  in  32 each  requester K instruction and operands.
REQ-007 mK_pcpi_wr  out  1  requester K result write enable.
REQ-008 mK_pcpi_rd  out  32  requester K result.
REQ-009 mK_pcpi_wait  out  1  requester K stall.
REQ-010 mK_pcpi_ready  out  1  requester K completion pulse.
REQ-011 s_pcpi_valid / s_pcpi_insn / s_pcpi_rs1 / s_pcpi_rs2  out  1/32/32/32  request to the shared SRFPU.
REQ-012 s_pcpi_wr / s_pcpi_rd / s_pcpi_wait / s_pcpi_ready  in  1/32/1/1  response from the SRFPU.
REQ-013 grant_o  out  1  index of the owning requester; valid only while busy_o=1.
REQ-014 busy_o  out  1  state is not IDLE.
REQ-015 timeout_o  out  1  one-cycle pulse when an issue is aborted by timeout.

Function
REQ-016 FSM states: IDLE, ISSUE, RELEASE.
REQ-017 IDLE: with exactly one valid, grant that requester; with both valid, grant the requester not served last (rr_ptr); transition to ISSUE next cycle.
REQ-018 On grant: latch insn/rs1/rs2 into holding registers; s_pcpi_valid=1 from the next cycle, driven only from registers.
REQ-019 ISSUE: hold s_pcpi_valid and s_pcpi_* stable until s_pcpi_ready=1.
REQ-020 s_pcpi_ready in ISSUE: next cycle mG_pcpi_ready=1 for one cycle with latched s_pcpi_wr/s_pcpi_rd; s_pcpi_valid=0; state RELEASE; rr_ptr = other requester.
REQ-021 RELEASE: exactly one cycle, then IDLE; no grant is made in RELEASE, which gives the requester time to drop valid.
REQ-022 mK_pcpi_wait=1 while mK_pcpi_valid=1 and K is not the owner, or K is the owner in ISSUE and (s_pcpi_wait=1 or the timeout counter < TIMEOUT); otherwise 0.
REQ-023 Timeout counter: clears on entry to ISSUE, and clears whenever s_pcpi_wait=1; otherwise increments in ISSUE and saturates.
REQ-024 Counter reaching TIMEOUT with s_pcpi_wait=0: drop owner wait, drop s_pcpi_valid, pulse timeout_o, state RELEASE, flip rr_ptr; mG_pcpi_ready stays 0 so the core traps on an illegal instruction.
REQ-025 Owner drops mG_pcpi_valid in ISSUE (abort): s_pcpi_valid=0 next cycle, state RELEASE, no ready pulse, flip rr_ptr.
REQ-026 s_pcpi_ready in IDLE or RELEASE (stale): SHALL be ignored; no requester output changes.
REQ-027 s_pcpi_ready and owner abort in the same cycle: abort wins; no ready pulse.
REQ-028 mK_pcpi_wr and mK_pcpi_ready SHALL be 0 for the non-owner at all times; mK_pcpi_rd is 0 except during K's ready pulse.
REQ-029 Minimum latency: request at cycle t, s_pcpi_valid at t+1, result at requester one cycle after s_pcpi_ready.

Reset
REQ-030 resetn=0: state IDLE, rr_ptr=0, counter=0, holding registers=0, all outputs 0, immediately and asynchronously.
REQ-031 Reset mid-ISSUE: s_pcpi_valid drops immediately; no pulse is emitted after release.

Structure
REQ-032 The shared package (srfpu_pkg) SHALL hold the FSM state enum and the PCPI field-width constants.
REQ-033 One sub-module, srfpu_rr_pick (2-way round-robin picker: inputs valid[1:0] and rr_ptr, outputs grant index and grant valid), is natural; the rest of the block is flat.

Verification
REQ-034 m0 valid alone, insn=0x0020F053, SRFPU wait=1 then ready at +5 with rd=0x40400000 -> m0 ready pulse one cycle later with rd=0x40400000; m1 outputs stay 0.
REQ-035 m0 and m1 valid in the same cycle, rr_ptr=0 -> m0 served first with m1 wait=1 throughout; m1 served after RELEASE; a later simultaneous request grants m0.
REQ-036 SRFPU never asserts wait or ready, TIMEOUT=16 -> owner wait drops 16 cycles after the ISSUE cycles begin; timeout_o pulses; s_pcpi_valid=0; no ready pulse.
REQ-037 Owner drops valid at ISSUE+3, then SRFPU ready at ISSUE+6 -> no ready pulse to either requester; arbiter back to IDLE after RELEASE.
REQ-038 resetn low at ISSUE+2 -> all outputs 0 the same cycle; after release the first request is granted to m0.
REQ-039 Operands change on m0 pcpi_rs1 during ISSUE -> s_pcpi_rs1 holds its latched value.
